// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder (adder_seq).
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   // Index counter width: clog2 of the chunk count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built as an explicit full-adder chain.
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic carry;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      s     = '0;
      carry = c;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle ripple adder: WIDTH bits added CHUNK bits per cycle behind valid/ready.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN (adds the sub input).
module adder_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
`ifdef ADDER_SEQ_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = idx_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("adder_seq: WIDTH must be a positive multiple of CHUNK");
   end

   adder_state_t     state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic             sub_op;
   logic [31:0]      base;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_cout;

`ifdef ADDER_SEQ_SUB_EN
   assign sub_op = sub;
`else
   assign sub_op = 1'b0;
`endif

   assign base = 32'(idx_q) * 32'(CHUNK);

   // One shared chunk adder; the active chunk is selected by the index counter.
   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_q[base +: CHUNK]),
      .b    (b_q[base +: CHUNK]),
      .c    (carry_q),
      .s    (chunk_s),
      .cout (chunk_cout)
   );

   // NOTE: state is updated with non-blocking assignments only; all next values come from the comb blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)            state_d = RUN;
         RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
         DONE:    if (out_ready)           state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // Working sum is built chunk by chunk; the visible s/cout only move on the last chunk.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub_op ? ~b : b;
               carry_d = sub_op ? 1'b1 : c;
               idx_d   = '0;
            end
         end
         RUN: begin
            sum_d[base +: CHUNK] = chunk_s;
            carry_d              = chunk_cout;
            if (idx_q == LAST_IDX) begin
               s_d    = sum_d;
               cout_d = chunk_cout;
               idx_d  = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      s         = s_q;
      cout      = cout_q;
   end

endmodule

// File: tb/tb_adder_seq.sv
// Directed self-checking bench for adder_seq across several WIDTH/CHUNK builds.
module tb_adder_seq;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   // 8-bit, 2-bit chunks (N=4)
   logic       p82_in_valid, p82_in_ready, p82_c, p82_out_valid, p82_out_ready, p82_cout;
   logic [7:0] p82_a, p82_b, p82_s;
   // 16-bit, 4-bit chunks (N=4)
   logic        p164_in_valid, p164_in_ready, p164_c, p164_out_valid, p164_out_ready, p164_cout;
   logic [15:0] p164_a, p164_b, p164_s;
   // 8-bit, single chunk (N=1)
   logic       p88_in_valid, p88_in_ready, p88_c, p88_out_valid, p88_out_ready, p88_cout;
   logic [7:0] p88_a, p88_b, p88_s;
   // 8-bit, 4-bit chunks (N=2)
   logic       p84_in_valid, p84_in_ready, p84_c, p84_out_valid, p84_out_ready, p84_cout;
   logic [7:0] p84_a, p84_b, p84_s;
`ifdef ADDER_SEQ_SUB_EN
   logic       p84_sub;
`endif

   adder_seq #(.WIDTH(8), .CHUNK(2)) u_p82 (
      .clk(clk), .rst_n(rst_n), .in_valid(p82_in_valid), .in_ready(p82_in_ready),
      .a(p82_a), .b(p82_b), .c(p82_c),
`ifdef ADDER_SEQ_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(p82_out_valid), .out_ready(p82_out_ready), .s(p82_s), .cout(p82_cout)
   );

   adder_seq #(.WIDTH(16), .CHUNK(4)) u_p164 (
      .clk(clk), .rst_n(rst_n), .in_valid(p164_in_valid), .in_ready(p164_in_ready),
      .a(p164_a), .b(p164_b), .c(p164_c),
`ifdef ADDER_SEQ_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(p164_out_valid), .out_ready(p164_out_ready), .s(p164_s), .cout(p164_cout)
   );

   adder_seq #(.WIDTH(8), .CHUNK(8)) u_p88 (
      .clk(clk), .rst_n(rst_n), .in_valid(p88_in_valid), .in_ready(p88_in_ready),
      .a(p88_a), .b(p88_b), .c(p88_c),
`ifdef ADDER_SEQ_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(p88_out_valid), .out_ready(p88_out_ready), .s(p88_s), .cout(p88_cout)
   );

   adder_seq #(.WIDTH(8), .CHUNK(4)) u_p84 (
      .clk(clk), .rst_n(rst_n), .in_valid(p84_in_valid), .in_ready(p84_in_ready),
      .a(p84_a), .b(p84_b), .c(p84_c),
`ifdef ADDER_SEQ_SUB_EN
      .sub(p84_sub),
`endif
      .out_valid(p84_out_valid), .out_ready(p84_out_ready), .s(p84_s), .cout(p84_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks += 4;
      if (p82_in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", p82_in_ready); end
      if (p82_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", p82_out_valid); end
      if (p164_s !== 16'h0000)    begin errors++; $display("FAIL reset_s: got %h want 0000", p164_s); end
      if (p88_cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b want 0", p88_cout); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // 0xFF + 0x01 over 4 chunks; a second request held during RUN/DONE must be ignored.
   task automatic test_wrap_8x2();
      checks++;
      if (p82_in_ready !== 1'b1) begin errors++; $display("FAIL wrap_idle_ready: got %b want 1", p82_in_ready); end
      p82_a = 8'hFF; p82_b = 8'h01; p82_c = 1'b0; p82_in_valid = 1'b1;
      step();
      p82_a = 8'h11; p82_b = 8'h22; p82_c = 1'b1;
      checks++;
      if (p82_in_ready !== 1'b0) begin errors++; $display("FAIL wrap_run_ready: got %b want 0", p82_in_ready); end
      step(); step(); step();
      checks++;
      if (p82_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_early_valid: got %b want 0", p82_out_valid); end
      step();
      checks += 4;
      if (p82_out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", p82_out_valid); end
      if (p82_s !== 8'h00)        begin errors++; $display("FAIL wrap_s: got %h want 00", p82_s); end
      if (p82_cout !== 1'b1)      begin errors++; $display("FAIL wrap_cout: got %b want 1", p82_cout); end
      if (p82_in_ready !== 1'b0)  begin errors++; $display("FAIL wrap_done_ready: got %b want 0", p82_in_ready); end
      step();
      checks += 2;
      if (p82_out_valid !== 1'b1 || p82_s !== 8'h00) begin
         errors++; $display("FAIL wrap_done_hold: got valid=%b s=%h want valid=1 s=00", p82_out_valid, p82_s);
      end
      if (p82_in_ready !== 1'b0) begin errors++; $display("FAIL wrap_done_ignore: got %b want 0", p82_in_ready); end
      p82_in_valid = 1'b0;
      p82_out_ready = 1'b1;
      step();
      p82_out_ready = 1'b0;
      checks += 2;
      if (p82_out_valid !== 1'b0 || p82_in_ready !== 1'b1) begin
         errors++; $display("FAIL wrap_drain: got valid=%b ready=%b want 0/1", p82_out_valid, p82_in_ready);
      end
      if (p82_s !== 8'h00 || p82_cout !== 1'b1) begin
         errors++; $display("FAIL wrap_idle_keep: got s=%h cout=%b want 00/1", p82_s, p82_cout);
      end
   endtask

   // 0x1234 + 0x4321 + 1 with a stalled consumer.
   task automatic test_stall_16x4();
      p164_a = 16'h1234; p164_b = 16'h4321; p164_c = 1'b1; p164_in_valid = 1'b1;
      step();
      p164_in_valid = 1'b0;
      step(); step(); step(); step();
      checks += 2;
      if (p164_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", p164_out_valid); end
      if (p164_s !== 16'h5556 || p164_cout !== 1'b0) begin
         errors++; $display("FAIL stall_result: got s=%h cout=%b want 5556/0", p164_s, p164_cout);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (p164_out_valid !== 1'b1 || p164_s !== 16'h5556) begin
            errors++; $display("FAIL stall_hold%0d: got valid=%b s=%h want 1/5556", i, p164_out_valid, p164_s);
         end
      end
      p164_out_ready = 1'b1;
      #1;
      checks++;
      if (p164_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_same: got %b want 0", p164_in_ready); end
      step();
      p164_out_ready = 1'b0;
      checks++;
      if (p164_in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_next: got %b want 1", p164_in_ready); end
   endtask

   // N=1: a single RUN cycle.
   task automatic test_single_chunk();
      p88_a = 8'h80; p88_b = 8'h80; p88_c = 1'b1; p88_in_valid = 1'b1;
      step();
      p88_in_valid = 1'b0;
      checks++;
      if (p88_out_valid !== 1'b0 || p88_in_ready !== 1'b0) begin
         errors++; $display("FAIL single_run: got valid=%b ready=%b want 0/0", p88_out_valid, p88_in_ready);
      end
      step();
      checks += 2;
      if (p88_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", p88_out_valid); end
      if (p88_s !== 8'h01 || p88_cout !== 1'b1) begin
         errors++; $display("FAIL single_result: got s=%h cout=%b want 01/1", p88_s, p88_cout);
      end
      p88_out_ready = 1'b1;
      step();
      p88_out_ready = 1'b0;
   endtask

   // Consumer always ready; second request queued behind the first.
   task automatic test_back_to_back();
      logic [7:0] res [2];
      int         got;
      int         gap;
      got = 0;
      p82_out_ready = 1'b1;
      p82_a = 8'h01; p82_b = 8'h02; p82_c = 1'b0; p82_in_valid = 1'b1;
      for (int op = 0; op < 2; op++) begin
         step();
         if (op == 0) begin
            p82_a = 8'h03; p82_b = 8'h04;
         end else begin
            p82_in_valid = 1'b0;
         end
         gap = 1;
         while (p82_in_ready !== 1'b1 && gap < 20) begin
            if (p82_out_valid === 1'b1 && got < 2) begin
               res[got] = p82_s;
               got++;
            end
            step();
            gap++;
         end
         checks++;
         if (gap !== 6) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 6", op, gap); end
      end
      p82_out_ready = 1'b0;
      checks++;
      if (got !== 2) begin
         errors++; $display("FAIL b2b_count: got %0d want 2", got);
      end else begin
         checks++;
         if (res[0] !== 8'h03 || res[1] !== 8'h07) begin
            errors++; $display("FAIL b2b_order: got %h,%h want 03,07", res[0], res[1]);
         end
      end
   endtask

   // Reset mid-RUN aborts, clears outputs, then a fresh op completes.
   task automatic test_reset_abort();
      p82_a = 8'h33; p82_b = 8'h44; p82_c = 1'b0; p82_in_valid = 1'b1;
      step();
      p82_in_valid = 1'b0;
      step(); step();
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (p82_in_ready !== 1'b1 || p82_out_valid !== 1'b0) begin
         errors++; $display("FAIL abort_hs: got ready=%b valid=%b want 1/0", p82_in_ready, p82_out_valid);
      end
      if (p82_s !== 8'h00 || p82_cout !== 1'b0) begin
         errors++; $display("FAIL abort_out: got s=%h cout=%b want 00/0", p82_s, p82_cout);
      end
      if (p164_s !== 16'h0000) begin errors++; $display("FAIL abort_other_s: got %h want 0000", p164_s); end
      #1;
      rst_n = 1'b1;
      step();
      checks++;
      if (p82_out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b want 0", p82_out_valid); end
      p82_a = 8'h0F; p82_b = 8'h01; p82_c = 1'b0; p82_in_valid = 1'b1;
      step();
      p82_in_valid = 1'b0;
      step(); step(); step(); step();
      checks++;
      if (p82_out_valid !== 1'b1 || p82_s !== 8'h10 || p82_cout !== 1'b0) begin
         errors++; $display("FAIL abort_recover: got valid=%b s=%h cout=%b want 1/10/0", p82_out_valid, p82_s, p82_cout);
      end
      p82_out_ready = 1'b1;
      step();
      p82_out_ready = 1'b0;
   endtask

   // Runs a single op on the 8/4 instance and returns s/cout once out_valid appears.
   task automatic run_p84(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output logic [7:0] sv, output logic co, output logic ok);
      p84_a = av; p84_b = bv; p84_c = cv; p84_in_valid = 1'b1;
      step();
      p84_in_valid = 1'b0;
      step(); step();
      ok = p84_out_valid;
      sv = p84_s;
      co = p84_cout;
      p84_out_ready = 1'b1;
      step();
      p84_out_ready = 1'b0;
   endtask

   task automatic test_chunk_8x4();
      logic [7:0] sv;
      logic       co, ok;
      run_p84(8'h0F, 8'h01, 1'b1, sv, co, ok);
      checks++;
      if (ok !== 1'b1 || sv !== 8'h11 || co !== 1'b0) begin
         errors++; $display("FAIL add84: got valid=%b s=%h cout=%b want 1/11/0", ok, sv, co);
      end
   endtask

`ifdef ADDER_SEQ_SUB_EN
   task automatic test_sub();
      logic [7:0] sv;
      logic       co, ok;
      p84_sub = 1'b1;
      run_p84(8'h05, 8'h07, 1'b0, sv, co, ok);
      checks++;
      if (ok !== 1'b1 || sv !== 8'hFE || co !== 1'b0) begin
         errors++; $display("FAIL sub_borrow: got valid=%b s=%h cout=%b want 1/FE/0", ok, sv, co);
      end
      run_p84(8'h07, 8'h05, 1'b1, sv, co, ok);
      checks++;
      if (ok !== 1'b1 || sv !== 8'h02 || co !== 1'b1) begin
         errors++; $display("FAIL sub_noborrow: got valid=%b s=%h cout=%b want 1/02/1", ok, sv, co);
      end
      p84_sub = 1'b0;
      run_p84(8'h07, 8'h05, 1'b1, sv, co, ok);
      checks++;
      if (ok !== 1'b1 || sv !== 8'h0D || co !== 1'b0) begin
         errors++; $display("FAIL sub_off: got valid=%b s=%h cout=%b want 1/0D/0", ok, sv, co);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      p82_in_valid  = 1'b0; p82_out_ready  = 1'b0; p82_a  = '0; p82_b  = '0; p82_c  = 1'b0;
      p164_in_valid = 1'b0; p164_out_ready = 1'b0; p164_a = '0; p164_b = '0; p164_c = 1'b0;
      p88_in_valid  = 1'b0; p88_out_ready  = 1'b0; p88_a  = '0; p88_b  = '0; p88_c  = 1'b0;
      p84_in_valid  = 1'b0; p84_out_ready  = 1'b0; p84_a  = '0; p84_b  = '0; p84_c  = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      p84_sub = 1'b0;
`endif
      test_reset();
      test_wrap_8x2();
      test_stall_16x4();
      test_single_chunk();
      test_back_to_back();
      test_reset_abort();
      test_chunk_8x4();
`ifdef ADDER_SEQ_SUB_EN
      test_sub();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
